// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA write controller.
// Holds the scheduler state encoding, default widths and status codes.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StIssue,
    StWaitSts
  } sched_state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_LEN_W  = 26;

  localparam logic STS_OKAY = 1'b1;
  localparam logic STS_ERR  = 1'b0;

  // Index width that stays legal for a single channel.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping to the lowest index when nothing at or above ptr is requesting.
module dma_rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!any && req[c] && (IDX_W'(c) >= ptr)) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
    // Wrapped pass: lowest requester wins when none sit at or above ptr.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/dma_write_ctrl_mc.sv
// Multi-channel DMA write controller: splits per-channel jobs into chunks and
// interleaves them round-robin onto a single command port, one command in flight.
module dma_write_ctrl_mc
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned CHUNK_BYTES = 4096,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_idle,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [LEN_W-1:0]         cmd_btt,
  output logic                     cmd_eof,
  output logic [TAG_W-1:0]         cmd_tag,
  input  logic                     sts_valid,
  input  logic [TAG_W-1:0]         sts_tag,
  input  logic                     sts_okay,
  output logic [NUM_CH-1:0]        int_out,
  output logic [NUM_CH-1:0]        ch_err
);

  localparam int unsigned      IDX_W = idx_width(NUM_CH);
  localparam logic [LEN_W-1:0] CHUNK = LEN_W'(CHUNK_BYTES);

  sched_state_e state_q, state_d;

  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [NUM_CH-1:0] int_q, int_d;
  logic [NUM_CH-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [ADDR_W-1:0] addr_d [NUM_CH];
  logic [LEN_W-1:0]  rem_q  [NUM_CH];
  logic [LEN_W-1:0]  rem_d  [NUM_CH];
  logic [IDX_W-1:0]  rr_q, rr_d;

  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_btt_q, cmd_btt_d;
  logic              cmd_eof_q, cmd_eof_d;
  logic [TAG_W-1:0]  cmd_tag_q, cmd_tag_d;

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              sts_hit;
  logic              more;

  assign accept  = ch_valid & ~busy_q;
  assign sts_hit = sts_valid && (sts_tag == cmd_tag_q);

  // A channel still has chunks to issue; zero-length and aborted jobs never do.
  always_comb begin
    pending = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pending[c] = busy_q[c] && (rem_q[c] != '0);
    end
  end

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (pending),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    err_d      = err_q;
    int_d      = '0;
    cur_d      = cur_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rr_d       = rr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_btt_d  = cmd_btt_q;
    cmd_eof_d  = cmd_eof_q;
    cmd_tag_d  = cmd_tag_q;
    more       = 1'b0;

    // The channel frees up the cycle after its completion pulse.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (int_q[c]) begin
        busy_d[c] = 1'b0;
      end
      if (accept[c]) begin
        busy_d[c] = 1'b1;
        addr_d[c] = ch_addr[c*ADDR_W +: ADDR_W];
        rem_d[c]  = ch_len[c*LEN_W +: LEN_W];
        err_d[c]  = 1'b0;
        if (ch_len[c*LEN_W +: LEN_W] == '0) begin
          int_d[c] = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (grant_any) begin
          cur_d     = grant;
          cmd_tag_d = TAG_W'(grant_idx);
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
              cmd_addr_d = addr_q[c];
              cmd_btt_d  = (rem_q[c] > CHUNK) ? CHUNK : rem_q[c];
              cmd_eof_d  = (rem_q[c] <= CHUNK);
            end
          end
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          state_d = StWaitSts;
        end
      end
      StWaitSts: begin
        if (sts_hit) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cur_q[c]) begin
              unique case (sts_okay)
                STS_OKAY: begin
                  addr_d[c] = addr_q[c] + ADDR_W'(cmd_btt_q);
                  rem_d[c]  = rem_q[c] - cmd_btt_q;
                  if (cmd_eof_q) begin
                    int_d[c] = 1'b1;
                  end
                end
                STS_ERR: begin
                  rem_d[c] = '0;
                  err_d[c] = 1'b1;
                  int_d[c] = 1'b1;
                end
              endcase
              rr_d = (c == NUM_CH - 1) ? '0 : IDX_W'(c + 1);
            end
          end
          more    = (|(pending & ~cur_q)) || (sts_okay && !cmd_eof_q);
          state_d = more ? StArb : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      busy_q     <= '0;
      err_q      <= '0;
      int_q      <= '0;
      cur_q      <= '0;
      rr_q       <= '0;
      cmd_addr_q <= '0;
      cmd_btt_q  <= '0;
      cmd_eof_q  <= 1'b0;
      cmd_tag_q  <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      int_q      <= int_d;
      cur_q      <= cur_d;
      rr_q       <= rr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_btt_q  <= cmd_btt_d;
      cmd_eof_q  <= cmd_eof_d;
      cmd_tag_q  <= cmd_tag_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= addr_d[c];
        rem_q[c]  <= rem_d[c];
      end
    end
  end

  assign ch_idle   = ~busy_q;
  assign cmd_valid = (state_q == StIssue);
  assign cmd_addr  = cmd_addr_q;
  assign cmd_btt   = cmd_btt_q;
  assign cmd_eof   = cmd_eof_q;
  assign cmd_tag   = cmd_tag_q;
  assign int_out   = int_q;
  assign ch_err    = err_q;

endmodule

// File: tb/tb_dma_write_ctrl_mc.sv
// Directed bench for dma_write_ctrl_mc with 32-byte chunks and two channels.
// Expected commands are queued as jobs are driven and checked at each handshake.
module tb_dma_write_ctrl_mc;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 26;
  localparam int unsigned CB     = 32;
  localparam int unsigned TAG_W  = 4;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_idle;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [LEN_W-1:0]         cmd_btt;
  logic                     cmd_eof;
  logic [TAG_W-1:0]         cmd_tag;
  logic                     sts_valid;
  logic [TAG_W-1:0]         sts_tag;
  logic                     sts_okay;
  logic [NUM_CH-1:0]        int_out;
  logic [NUM_CH-1:0]        ch_err;

  always #5 CLK = ~CLK;

  dma_write_ctrl_mc #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .CHUNK_BYTES (CB),
    .TAG_W       (TAG_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ch_valid  (ch_valid),
    .ch_idle   (ch_idle),
    .ch_addr   (ch_addr),
    .ch_len    (ch_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_btt   (cmd_btt),
    .cmd_eof   (cmd_eof),
    .cmd_tag   (cmd_tag),
    .sts_valid (sts_valid),
    .sts_tag   (sts_tag),
    .sts_okay  (sts_okay),
    .int_out   (int_out),
    .ch_err    (ch_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  btt;
    logic              eof;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_vec         = 0;
  int   n_fail        = 0;
  int   n_cmd         = 0;
  int   sts_delay     = 2;
  int   err_countdown = 0;
  bit   foreign_first = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Command monitor and status responder: the only driver of the sts_* inputs.
  cmd_t             mon_e;
  logic [TAG_W-1:0] mon_t;
  logic             mon_ok;
  initial begin
    sts_valid = 1'b0;
    sts_tag   = '0;
    sts_okay  = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && cmd_valid && cmd_ready) begin
        n_cmd++;
        mon_t = cmd_tag;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $error("FAIL unexpected_cmd: observed addr 0x%0h tag %0d, expected no command",
                 cmd_addr, cmd_tag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_addr", 64'(cmd_addr), 64'(mon_e.addr));
          chk("cmd_btt", 64'(cmd_btt), 64'(mon_e.btt));
          chk("cmd_eof", 64'(cmd_eof), 64'(mon_e.eof));
          chk("cmd_tag", 64'(cmd_tag), 64'(mon_e.tag));
        end
        mon_ok = 1'b1;
        if (err_countdown > 0) begin
          err_countdown--;
          mon_ok = (err_countdown != 0);
        end
        repeat (sts_delay) @(negedge CLK);
        if (foreign_first) begin
          sts_valid = 1'b1;
          sts_tag   = mon_t ^ 4'd1;
          sts_okay  = 1'b0;
          @(negedge CLK);
        end
        sts_valid = 1'b1;
        sts_tag   = mon_t;
        sts_okay  = mon_ok;
        @(negedge CLK);
        sts_valid = 1'b0;
        sts_okay  = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_job(input int ch, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] c;
    rem = len;
    while (rem != 0) begin
      c = (rem > LEN_W'(CB)) ? LEN_W'(CB) : rem;
      exp_q.push_back('{addr: a, btt: c, eof: (rem == c), tag: TAG_W'(ch)});
      a   = a + ADDR_W'(c);
      rem = rem - c;
    end
  endtask

  // Returns at the negedge of the cycle after the accept edge.
  task automatic accept(input int ch, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    for (int k = 0; k < 300 && !ch_idle[ch]; k++) @(negedge CLK);
    chk($sformatf("idle_before_accept_ch%0d", ch), 64'(ch_idle[ch]), 64'd1);
    ch_valid[ch]                  = 1'b1;
    ch_addr[ch*ADDR_W +: ADDR_W] = a;
    ch_len[ch*LEN_W +: LEN_W]    = len;
    @(negedge CLK);
    ch_valid[ch] = 1'b0;
  endtask

  task automatic wait_int(input int ch);
    int k;
    k = 0;
    while (!int_out[ch] && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk($sformatf("int_seen_ch%0d", ch), 64'(int_out[ch]), 64'd1);
    @(negedge CLK);
    chk($sformatf("int_one_cycle_ch%0d", ch), 64'(int_out[ch]), 64'd0);
    chk($sformatf("idle_after_int_ch%0d", ch), 64'(ch_idle[ch]), 64'd1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    tick(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"}, 64'(ch_idle), 64'h3);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_btt"}, 64'(cmd_btt), 64'd0);
    chk({tag, "_cmd_eof"}, 64'(cmd_eof), 64'd0);
    chk({tag, "_cmd_tag"}, 64'(cmd_tag), 64'd0);
    chk({tag, "_int_out"}, 64'(int_out), 64'd0);
    chk({tag, "_ch_err"}, 64'(ch_err), 64'd0);
  endtask

  initial begin
    int jobs;
    int c0;
    int k;
    RST       = 1'b0;
    ch_valid  = '0;
    ch_addr   = '0;
    ch_len    = '0;
    cmd_ready = 1'b1;
    tick(2);
    chk_reset_outputs("reset");
    RST = 1'b1;
    tick(1);

    // Single job: two chunks, first command three cycles after accept.
    push_job(0, 32'h0, 26'h40);
    accept(0, 32'h0, 26'h40);
    chk("busy_n1", 64'(ch_idle[0]), 64'd0);
    chk("no_cmd_n1", 64'(cmd_valid), 64'd0);
    tick(1);
    chk("no_cmd_n2", 64'(cmd_valid), 64'd0);
    tick(1);
    chk("first_cmd_n3", 64'(cmd_valid), 64'd1);
    wait_int(0);
    chk("single_queue_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back jobs covering 0x0..0x83F contiguously.
    c0   = n_cmd;
    jobs = 0;
    for (logic [ADDR_W-1:0] a = 0; a <= 32'h800; a += 32'h40) begin
      push_job(0, a, 26'h40);
      accept(0, a, 26'h40);
      wait_int(0);
      jobs++;
    end
    chk("b2b_jobs", 64'(jobs), 64'd33);
    chk("b2b_cmds", 64'(n_cmd - c0), 64'd66);
    chk("b2b_queue_drained", 64'(exp_q.size()), 64'd0);

    // Interleave two channels accepted in the same cycle.
    do_reset();
    exp_q.push_back('{addr: 32'h1000, btt: 26'h20, eof: 1'b0, tag: 4'd0});
    exp_q.push_back('{addr: 32'h2000, btt: 26'h20, eof: 1'b0, tag: 4'd1});
    exp_q.push_back('{addr: 32'h1020, btt: 26'h20, eof: 1'b1, tag: 4'd0});
    exp_q.push_back('{addr: 32'h2020, btt: 26'h20, eof: 1'b0, tag: 4'd1});
    exp_q.push_back('{addr: 32'h2040, btt: 26'h20, eof: 1'b1, tag: 4'd1});
    ch_valid = 2'b11;
    ch_addr  = {32'h2000, 32'h1000};
    ch_len   = {26'h60, 26'h40};
    @(negedge CLK);
    ch_valid = 2'b00;
    k = 0;
    while (int_out == 0 && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("interleave_first_int", 64'(int_out), 64'h1);
    wait_int(1);
    chk("interleave_queue_drained", 64'(exp_q.size()), 64'd0);

    // Second chunk of ch1 fails: job aborts, error sticks until the next accept.
    do_reset();
    err_countdown = 2;
    exp_q.push_back('{addr: 32'h3000, btt: 26'h20, eof: 1'b0, tag: 4'd1});
    exp_q.push_back('{addr: 32'h3020, btt: 26'h20, eof: 1'b0, tag: 4'd1});
    accept(1, 32'h3000, 26'h60);
    wait_int(1);
    chk("err_set", 64'(ch_err), 64'h2);
    tick(10);
    chk("err_no_more_cmds", 64'(exp_q.size()), 64'd0);
    chk("err_still_set", 64'(ch_err), 64'h2);
    push_job(1, 32'h4000, 26'h10);
    accept(1, 32'h4000, 26'h10);
    chk("err_cleared_on_accept", 64'(ch_err), 64'h0);
    wait_int(1);

    // Backpressure: command held stable while cmd_ready is low.
    cmd_ready = 1'b0;
    push_job(0, 32'h5000, 26'h20);
    accept(0, 32'h5000, 26'h20);
    k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge CLK);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(cmd_valid), 64'd1);
      chk("bp_addr", 64'(cmd_addr), 64'h5000);
      chk("bp_btt", 64'(cmd_btt), 64'h20);
      chk("bp_eof", 64'(cmd_eof), 64'd1);
      chk("bp_tag", 64'(cmd_tag), 64'd0);
      tick(1);
    end
    @(posedge CLK);
    #1 cmd_ready = 1'b1;
    wait_int(0);

    // Zero-length job: pulse in N+1, idle again in N+2, no command.
    accept(1, 32'h5100, 26'h0);
    chk("zero_int_n1", 64'(int_out), 64'h2);
    chk("zero_no_cmd_n1", 64'(cmd_valid), 64'd0);
    chk("zero_busy_n1", 64'(ch_idle[1]), 64'd0);
    tick(1);
    chk("zero_int_done_n2", 64'(int_out), 64'h0);
    chk("zero_idle_n2", 64'(ch_idle[1]), 64'd1);
    tick(5);
    chk("zero_still_no_cmd", 64'(cmd_valid), 64'd0);

    // A failing status with the other channel's tag must be ignored.
    foreign_first = 1'b1;
    push_job(0, 32'h6000, 26'h20);
    accept(0, 32'h6000, 26'h20);
    wait_int(0);
    chk("foreign_no_err", 64'(ch_err), 64'h0);
    foreign_first = 1'b0;

    // Reset while waiting on status; the late status must not revive the job.
    sts_delay = 6;
    exp_q.push_back('{addr: 32'h7000, btt: 26'h20, eof: 1'b0, tag: 4'd0});
    c0 = n_cmd;
    accept(0, 32'h7000, 26'h40);
    k = 0;
    while (n_cmd == c0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("midrst_cmd_seen", 64'(n_cmd - c0), 64'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("midrst");
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("late_no_cmd", 64'(cmd_valid), 64'd0);
      chk("late_no_int", 64'(int_out), 64'h0);
    end
    chk("late_idle", 64'(ch_idle), 64'h3);
    chk("late_queue_drained", 64'(exp_q.size()), 64'd0);
    sts_delay = 2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_write_ctrl_mc.md
Name: dma_write_ctrl_mc

Overview:
- Multi-channel successor to the single-channel DMA write controller.
- Accepts per-channel (destination address, byte length) jobs through a valid/idle handshake.
- Splits each job into chunks of at most CHUNK_BYTES and interleaves channels round-robin onto one S2MM-style command port.
- Tracks completion status per chunk and raises a per-channel interrupt when a job finishes or fails.

Parameters:
- NUM_CH, 2, number of job channels (1..8).
- ADDR_W, 32, destination address width.
- LEN_W, 26, job length / bytes-to-transfer width.
- CHUNK_BYTES, 4096, maximum bytes per issued command; power of two, < 2**LEN_W.
- TAG_W, 4, command/status tag width; must satisfy 2**TAG_W >= NUM_CH.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-low reset
- ch_valid  in  NUM_CH  job request per channel
- ch_idle  out  NUM_CH  channel free; job accepted when ch_valid[i] & ch_idle[i]
- ch_addr  in  NUM_CH*ADDR_W  packed destination addresses, channel i at bits [i*ADDR_W +: ADDR_W]
- ch_len  in  NUM_CH*LEN_W  packed byte lengths
- cmd_valid  out  1  command valid
- cmd_ready  in  1  command accepted by datamover
- cmd_addr  out  ADDR_W  chunk start address
- cmd_btt  out  LEN_W  chunk byte count
- cmd_eof  out  1  last chunk of the job
- cmd_tag  out  TAG_W  issuing channel index
- sts_valid  in  1  status return
- sts_tag  in  TAG_W  status tag
- sts_okay  in  1  1 = chunk written OK
- int_out  out  NUM_CH  one-cycle completion pulse
- ch_err  out  NUM_CH  sticky error flag, cleared on the next accept of that channel

Behaviour:
- Reset (RST=0 at a CLK edge):
  - ch_idle = all ones; cmd_valid, cmd_addr, cmd_btt, cmd_eof, cmd_tag, int_out, ch_err = 0.
  - All per-channel state is cleared and the round-robin pointer is set to 0.
  - Reset mid-operation abandons all jobs; cmd_valid is low in the cycle after reset is sampled; late status is ignored.
- Accept at cycle N:
  - Latch addr/len into the channel registers, clear ch_err[i].
  - ch_idle[i] = 0 from cycle N+1.
- Scheduler FSM states: IDLE, ARB, ISSUE, WAIT_STS.
  - IDLE: go to ARB when any channel is pending.
  - ARB (1 cycle): pick the first pending channel at or after rr_ptr, wrapping modulo NUM_CH.
    - chunk = min(remaining, CHUNK_BYTES).
    - Load cmd_addr, cmd_btt=chunk, cmd_eof=(remaining==chunk), cmd_tag=i.
    - Go to ISSUE.
  - ISSUE: cmd_valid=1 and held stable until cmd_ready; on handshake go to WAIT_STS. First cmd_valid for a job accepted at N on an idle scheduler is at N+3.
  - WAIT_STS: wait for sts_valid with sts_tag equal to the issuing channel; status with any other tag is ignored.
    - sts_okay=1: addr += chunk (wraps modulo 2**ADDR_W), remaining -= chunk. If remaining==0: int_out[i] pulses 1 cycle and ch_idle[i]=1 the following cycle.
    - sts_okay=0: abort the job, ch_err[i]=1, int_out[i] pulse, ch_idle[i]=1.
    - Either case: rr_ptr = i+1 mod NUM_CH, then go to ARB if work remains, else IDLE.
- Only one command is outstanding at any time.
- ch_len=0: accepted; no command is issued. int_out[i] pulses in cycle N+1 and ch_idle[i] returns to 1 in cycle N+2.
- If ch_valid and the int/idle return of the same channel coincide, the new accept takes effect only after ch_idle is seen high; there is no same-cycle re-accept.
- Other channels may be accepted at any time, including while a job is mid-flight.

Decomposition:
- Shared package dma_pkg holds:
  - FSM state typedef (IDLE/ARB/ISSUE/WAIT_STS).
  - Default widths ADDR_W=32, LEN_W=26.
  - Status code constants.
- One sub-module, dma_rr_arbiter:
  - Inputs: NUM_CH request vector and pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational.

Test Plan:
- Use CHUNK_BYTES=32, NUM_CH=2, with cmd_ready=1 and an okay status 2 cycles after each command unless stated otherwise.
- Single job, ch0 addr=0x0, len=0x40 → 2 commands, (0x0, 0x20, eof=0) then (0x20, 0x20, eof=1); one int_out[0] pulse; ch_idle[0] returns 1.
- Back-to-back jobs: re-issue whenever ch_idle[0] is high, addr +0x40 each time, until addr > 0x800 → 33 jobs, 66 commands, addresses contiguous 0x0..0x83F.
- Interleave: ch0 (0x1000, 0x40) and ch1 (0x2000, 0x60) accepted the same cycle → command order 0x1000, 0x2000, 0x1020, 0x2020, 0x2040; int_out[0] before int_out[1].
- Error: ch1 second chunk returns sts_okay=0 → no further ch1 commands; ch_err[1]=1, int_out[1] pulse; the next accept on ch1 clears ch_err[1].
- Backpressure and zero-length:
  - cmd_ready held 0 for 5 cycles → cmd_* stable throughout.
  - len=0 → no command issued, int_out pulse in cycle N+1.
  - A status with a foreign tag is ignored.
- Reset mid-job: RST=0 while in WAIT_STS → all outputs at reset values next cycle; the late status is ignored.
